// File: rtl/qrs_ref_pkg.sv
// Shared types and saturating helpers for the multi-lead QRS boundary refiner.
package qrs_ref_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam int unsigned QOffDef  = 8;
  localparam int unsigned SOffDef  = 15;
  localparam int unsigned ShiftDef = 3;

  // Working width of the helpers; callers keep W+SHIFT+1 within it.
  localparam int unsigned XW = 32;

  function automatic logic [XW-1:0] sat_max(input int unsigned w);
    return (XW'(1) << w) - XW'(1);
  endfunction

  function automatic logic [XW-1:0] sat_sub(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [XW-1:0] sat_add(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                            input int unsigned w);
    logic [XW-1:0] sum;
    sum = a + b;
    return (sum > sat_max(w)) ? sat_max(w) : sum;
  endfunction

  function automatic logic [XW-1:0] sat_shl(input logic [XW-1:0] a, input int unsigned sh,
                                            input int unsigned w);
    logic [XW-1:0] x;
    x = a << sh;
    return (x > sat_max(w)) ? sat_max(w) : x;
  endfunction

endpackage

// File: rtl/qrs_refinement_mc_if.sv
// Lead-data bus between the level-3 detectors, the refiner and the beat classifier.
interface qrs_refinement_mc_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 16,
  parameter int unsigned C1W = 4,
  parameter int unsigned C2W = 9
);
  logic [C1W-1:0]   count1;
  logic [C2W-1:0]   count2;
  logic [NCH-1:0]   qwindow_full;
  logic [NCH-1:0]   swindow_full;
  logic [NCH-1:0]   q_begin_l3_flag;
  logic [NCH-1:0]   s_end_l3_flag;
  logic [NCH*W-1:0] q_begin_l3;
  logic [NCH*W-1:0] s_end_l3;
  logic [NCH*W-1:0] q_begin_l3_temp;
  logic [NCH*W-1:0] s_end_l3_temp;
  logic [NCH*W-1:0] q_begin_ref;
  logic [NCH*W-1:0] s_end_ref;
  logic [NCH*W-1:0] qrs_width;
  logic [NCH-1:0]   ref_err;
  logic             ref_valid;
  logic             busy;
  logic             trig_miss;

  modport master (
    output count1, count2, qwindow_full, swindow_full, q_begin_l3_flag, s_end_l3_flag,
           q_begin_l3, s_end_l3,
    input  q_begin_l3_temp, s_end_l3_temp, q_begin_ref, s_end_ref, qrs_width, ref_err,
           ref_valid, busy, trig_miss
  );

  modport slave (
    input  count1, count2, qwindow_full, swindow_full, q_begin_l3_flag, s_end_l3_flag,
           q_begin_l3, s_end_l3,
    output q_begin_l3_temp, s_end_l3_temp, q_begin_ref, s_end_ref, qrs_width, ref_err,
           ref_valid, busy, trig_miss
  );
endinterface

// File: rtl/qrs_ref_chan_alu.sv
// Shared per-lead arithmetic: offset correction, rescale, width and causality check.
module qrs_ref_chan_alu
  import qrs_ref_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned SHIFT  = ShiftDef,
  parameter int unsigned QSUB   = QOffDef,
  parameter int unsigned SADD   = SOffDef,
  parameter bit          LEGACY = 1'b0
) (
  input  logic [W-1:0] q_in_i,
  input  logic [W-1:0] s_in_i,
  input  logic         q_upd_i,
  input  logic         s_upd_i,
  input  logic [W-1:0] q_temp_i,
  input  logic [W-1:0] s_temp_i,
  output logic [W-1:0] q_temp_o,
  output logic [W-1:0] s_temp_o,
  output logic [W-1:0] q_ref_o,
  output logic [W-1:0] s_ref_o,
  output logic [W-1:0] width_o,
  output logic         err_o,
  output logic         q_we_o,
  output logic         s_we_o,
  output logic         ref_we_o
);

  logic [W-1:0] q_dec, s_inc, q_src, s_src;

  always_comb begin
    q_we_o   = q_upd_i;
    s_we_o   = s_upd_i;
    q_dec    = W'(sat_sub(XW'(q_in_i), XW'(QSUB)));
    s_inc    = W'(sat_add(XW'(s_in_i), XW'(SADD), W));
    q_temp_o = q_upd_i ? q_dec : q_temp_i;
    s_temp_o = s_upd_i ? s_inc : s_temp_i;
    // Legacy mode rescales the pre-update temp, giving a one-frame lag.
    q_src    = LEGACY ? q_temp_i : q_temp_o;
    s_src    = LEGACY ? s_temp_i : s_temp_o;
    q_ref_o  = W'(sat_shl(XW'(q_src), SHIFT, W));
    s_ref_o  = W'(sat_shl(XW'(s_src), SHIFT, W));
    ref_we_o = s_ref_o > q_ref_o;
    err_o    = !ref_we_o;
    width_o  = s_ref_o - q_ref_o;
  end

endmodule

// File: rtl/qrs_refinement_mc.sv
// Multi-lead QRS boundary refiner: snapshots all leads on the frame strobe, then
// refines one lead per cycle through a single shared ALU.
module qrs_refinement_mc
  import qrs_ref_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned W      = 16,
  parameter int unsigned C1W    = 4,
  parameter int unsigned C2W    = 9,
  parameter int unsigned TRIG1  = 2,
  parameter int unsigned TRIG2  = 1,
  parameter int unsigned RAT    = 1,
  parameter int unsigned Q_OFF  = QOffDef,
  parameter int unsigned S_OFF  = SOffDef,
  parameter int unsigned SHIFT  = ShiftDef,
  parameter bit          LEGACY = 1'b0
) (
  input logic                clk,
  input logic                reset,
  qrs_refinement_mc_if.slave bus
);

  localparam int unsigned     IdxW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            snap_en, strobe;

  logic [W-1:0]   q_snap_q [NCH];
  logic [W-1:0]   s_snap_q [NCH];
  logic [NCH-1:0] q_upd_q, s_upd_q;
  logic [W-1:0]   q_temp_q [NCH];
  logic [W-1:0]   s_temp_q [NCH];
  logic [W-1:0]   q_ref_q  [NCH];
  logic [W-1:0]   s_ref_q  [NCH];
  logic [W-1:0]   width_q  [NCH];
  logic [NCH-1:0] err_q;
  logic           trig_miss_q;

  logic [W-1:0] alu_q_temp, alu_s_temp, alu_q_ref, alu_s_ref, alu_width;
  logic         alu_err, alu_q_we, alu_s_we, alu_ref_we;

  assign strobe = (bus.count1 == C1W'(TRIG1)) && (bus.count2 == C2W'(TRIG2));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          state_d = StCalc;
          idx_d   = '0;
          snap_en = 1'b1;
        end
      end
      StCalc: begin
        idx_d = idx_q + IdxW'(1);
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  qrs_ref_chan_alu #(
    .W      (W),
    .SHIFT  (SHIFT),
    .QSUB   (Q_OFF * RAT),
    .SADD   (S_OFF * RAT),
    .LEGACY (LEGACY)
  ) u_alu (
    .q_in_i   (q_snap_q[idx_q]),
    .s_in_i   (s_snap_q[idx_q]),
    .q_upd_i  (q_upd_q[idx_q]),
    .s_upd_i  (s_upd_q[idx_q]),
    .q_temp_i (q_temp_q[idx_q]),
    .s_temp_i (s_temp_q[idx_q]),
    .q_temp_o (alu_q_temp),
    .s_temp_o (alu_s_temp),
    .q_ref_o  (alu_q_ref),
    .s_ref_o  (alu_s_ref),
    .width_o  (alu_width),
    .err_o    (alu_err),
    .q_we_o   (alu_q_we),
    .s_we_o   (alu_s_we),
    .ref_we_o (alu_ref_we)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      q_upd_q     <= '0;
      s_upd_q     <= '0;
      err_q       <= '0;
      trig_miss_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        q_snap_q[k] <= '0;
        s_snap_q[k] <= '0;
        q_temp_q[k] <= '0;
        s_temp_q[k] <= '0;
        q_ref_q[k]  <= '0;
        s_ref_q[k]  <= '0;
        width_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (snap_en) begin
        q_upd_q <= bus.qwindow_full & bus.q_begin_l3_flag;
        s_upd_q <= bus.swindow_full & bus.s_end_l3_flag;
        for (int k = 0; k < NCH; k++) begin
          q_snap_q[k] <= bus.q_begin_l3[k*W +: W];
          s_snap_q[k] <= bus.s_end_l3[k*W +: W];
        end
      end
      if (state_q == StCalc) begin
        if (alu_q_we) q_temp_q[idx_q] <= alu_q_temp;
        if (alu_s_we) s_temp_q[idx_q] <= alu_s_temp;
        // Non-causal results keep the previous boundaries; only the flag moves.
        if (alu_ref_we) begin
          q_ref_q[idx_q] <= alu_q_ref;
          s_ref_q[idx_q] <= alu_s_ref;
          width_q[idx_q] <= alu_width;
        end
        err_q[idx_q] <= alu_err;
      end
      if (strobe && (state_q != StIdle)) trig_miss_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign bus.q_begin_l3_temp[k*W +: W] = q_temp_q[k];
    assign bus.s_end_l3_temp[k*W +: W]   = s_temp_q[k];
    assign bus.q_begin_ref[k*W +: W]     = q_ref_q[k];
    assign bus.s_end_ref[k*W +: W]       = s_ref_q[k];
    assign bus.qrs_width[k*W +: W]       = width_q[k];
  end

  assign bus.ref_err   = err_q;
  assign bus.ref_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.trig_miss = trig_miss_q;

endmodule

// File: tb/tb_qrs_refinement_mc.sv
// Scoreboard bench for qrs_refinement_mc: one instance per LEGACY setting.
module tb_qrs_refinement_mc;
  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCH*W-1:0] qt;
    logic [NCH*W-1:0] st;
    logic [NCH*W-1:0] qr;
    logic [NCH*W-1:0] sr;
    logic [NCH*W-1:0] wd;
    logic [NCH-1:0]   err;
    logic [31:0]      cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t stage;
  exp_t e0, e1;
  int unsigned t0;

  qrs_refinement_mc_if #(.NCH(NCH), .W(W), .C1W(4), .C2W(9)) bus0 ();
  qrs_refinement_mc_if #(.NCH(NCH), .W(W), .C1W(4), .C2W(9)) bus1 ();

  qrs_refinement_mc #(.NCH(NCH), .W(W), .LEGACY(1'b0)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
  );

  qrs_refinement_mc #(.NCH(NCH), .W(W), .LEGACY(1'b1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [NCH*W-1:0] qt,
                         input logic [NCH*W-1:0] st, input logic [NCH*W-1:0] qr,
                         input logic [NCH*W-1:0] sr, input logic [NCH*W-1:0] wd,
                         input logic [NCH-1:0] er);
    check({tag, " valid_cycle"}, 64'(cyc), 64'(e.cyc));
    check({tag, " q_temp"}, qt, e.qt);
    check({tag, " s_temp"}, st, e.st);
    check({tag, " q_ref"}, qr, e.qr);
    check({tag, " s_ref"}, sr, e.sr);
    check({tag, " width"}, wd, e.wd);
    check({tag, " ref_err"}, 64'(er), 64'(e.err));
  endtask

  always @(negedge clk) begin
    if (bus0.ref_valid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected ref_valid at cycle %0d: got 1 expected 0", cyc);
      end else begin
        e0 = q0.pop_front();
        compare("dut0", e0, bus0.q_begin_l3_temp, bus0.s_end_l3_temp, bus0.q_begin_ref,
                bus0.s_end_ref, bus0.qrs_width, bus0.ref_err);
      end
    end
    if (bus1.ref_valid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected ref_valid at cycle %0d: got 1 expected 0", cyc);
      end else begin
        e1 = q1.pop_front();
        compare("dut1", e1, bus1.q_begin_l3_temp, bus1.s_end_l3_temp, bus1.q_begin_ref,
                bus1.s_end_ref, bus1.qrs_width, bus1.ref_err);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lead(input int d, input int k, input logic [W-1:0] q, input logic [W-1:0] s,
                          input logic qw, input logic sw, input logic qf, input logic sf);
    if (d == 0) begin
      bus0.q_begin_l3[k*W +: W] = q;
      bus0.s_end_l3[k*W +: W]   = s;
      bus0.qwindow_full[k]      = qw;
      bus0.swindow_full[k]      = sw;
      bus0.q_begin_l3_flag[k]   = qf;
      bus0.s_end_l3_flag[k]     = sf;
    end else begin
      bus1.q_begin_l3[k*W +: W] = q;
      bus1.s_end_l3[k*W +: W]   = s;
      bus1.qwindow_full[k]      = qw;
      bus1.swindow_full[k]      = sw;
      bus1.q_begin_l3_flag[k]   = qf;
      bus1.s_end_l3_flag[k]     = sf;
    end
  endtask

  task automatic exp_lead(input int k, input logic [W-1:0] qt, input logic [W-1:0] st,
                          input logic [W-1:0] qr, input logic [W-1:0] sr,
                          input logic [W-1:0] wd, input logic er);
    stage.qt[k*W +: W] = qt;
    stage.st[k*W +: W] = st;
    stage.qr[k*W +: W] = qr;
    stage.sr[k*W +: W] = sr;
    stage.wd[k*W +: W] = wd;
    stage.err[k]       = er;
  endtask

  // Strobe is present for the current cycle; returns one cycle later.
  task automatic strobe(input int d);
    if (d == 0) begin
      bus0.count1 = 4'd2;
      bus0.count2 = 9'd1;
    end else begin
      bus1.count1 = 4'd2;
      bus1.count2 = 9'd1;
    end
    step(1);
    bus0.count1 = '0;
    bus0.count2 = '0;
    bus1.count1 = '0;
    bus1.count2 = '0;
  endtask

  task automatic set_frame_a();
    set_lead(0, 0, 16'd100, 16'd120, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 1, 16'd5, 16'd8190, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 2, 16'd200, 16'd300, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 3, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    stage = '0;
    bus0.count1 = '0; bus0.count2 = '0; bus0.qwindow_full = '0; bus0.swindow_full = '0;
    bus0.q_begin_l3_flag = '0; bus0.s_end_l3_flag = '0;
    bus0.q_begin_l3 = '0; bus0.s_end_l3 = '0;
    bus1.count1 = '0; bus1.count2 = '0; bus1.qwindow_full = '0; bus1.swindow_full = '0;
    bus1.q_begin_l3_flag = '0; bus1.s_end_l3_flag = '0;
    bus1.q_begin_l3 = '0; bus1.s_end_l3 = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    step(3);
    rst0 = 1'b0;
    rst1 = 1'b0;
    step(1);

    check("reset q_temp", bus0.q_begin_l3_temp, 64'd0);
    check("reset s_temp", bus0.s_end_l3_temp, 64'd0);
    check("reset q_ref", bus0.q_begin_ref, 64'd0);
    check("reset s_ref", bus0.s_end_ref, 64'd0);
    check("reset width", bus0.qrs_width, 64'd0);
    check("reset ref_err", 64'(bus0.ref_err), 64'd0);
    check("reset ref_valid", 64'(bus0.ref_valid), 64'd0);
    check("reset busy", 64'(bus0.busy), 64'd0);
    check("reset trig_miss", 64'(bus0.trig_miss), 64'd0);

    // Frame A: nominal lead, both saturation corners, zero inputs.
    set_frame_a();
    exp_lead(0, 16'd92, 16'd135, 16'd736, 16'd1080, 16'd344, 1'b0);
    exp_lead(1, 16'd0, 16'd8205, 16'd0, 16'd65535, 16'd65535, 1'b0);
    exp_lead(2, 16'd192, 16'd315, 16'd1536, 16'd2520, 16'd984, 1'b0);
    exp_lead(3, 16'd0, 16'd15, 16'd0, 16'd120, 16'd120, 1'b0);
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q0.push_back(stage);
    strobe(0);
    step(1);
    check("lead0 written at T+1", 64'(bus0.q_begin_ref[0 +: W]), 64'd736);
    check("lead1 not yet at T+1", 64'(bus0.q_begin_ref[W +: W]), 64'd0);
    check("busy during calc", 64'(bus0.busy), 64'd1);
    step(4);

    // Frame B: lead0 non-causal, lead2 q flag low, lead3 s window low.
    set_lead(0, 0, 16'd100, 16'd10, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 1, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 2, 16'd50, 16'd400, 1'b1, 1'b1, 1'b0, 1'b1);
    set_lead(0, 3, 16'd16, 16'd999, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_lead(0, 16'd92, 16'd25, 16'd736, 16'd1080, 16'd344, 1'b1);
    exp_lead(1, 16'd992, 16'd1015, 16'd7936, 16'd8120, 16'd184, 1'b0);
    exp_lead(2, 16'd192, 16'd415, 16'd1536, 16'd3320, 16'd1784, 1'b0);
    exp_lead(3, 16'd8, 16'd15, 16'd64, 16'd120, 16'd56, 1'b0);
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q0.push_back(stage);
    strobe(0);
    step(5);

    // Frame C: recovers lead0, re-strobe at T+2 is dropped.
    set_lead(0, 0, 16'd100, 16'd120, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 2, 16'd50, 16'd400, 1'b1, 1'b1, 1'b1, 1'b1);
    set_lead(0, 3, 16'd16, 16'd999, 1'b1, 1'b1, 1'b1, 1'b1);
    exp_lead(0, 16'd92, 16'd135, 16'd736, 16'd1080, 16'd344, 1'b0);
    exp_lead(2, 16'd42, 16'd415, 16'd336, 16'd3320, 16'd2984, 1'b0);
    exp_lead(3, 16'd8, 16'd1014, 16'd64, 16'd8112, 16'd8048, 1'b0);
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q0.push_back(stage);
    strobe(0);
    step(1);
    strobe(0);
    check("trig_miss after re-strobe", 64'(bus0.trig_miss), 64'd1);
    step(3);

    // Frame D: earliest accepted strobe, T+NCH+2 after frame C.
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q0.push_back(stage);
    strobe(0);
    step(5);
    check("trig_miss sticky", 64'(bus0.trig_miss), 64'd1);

    // Frame E: reset at T+2 aborts the pass.
    set_frame_a();
    strobe(0);
    step(1);
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    check("abort busy", 64'(bus0.busy), 64'd0);
    check("abort trig_miss", 64'(bus0.trig_miss), 64'd0);
    check("abort q_temp", bus0.q_begin_l3_temp, 64'd0);
    check("abort s_temp", bus0.s_end_l3_temp, 64'd0);
    check("abort q_ref", bus0.q_begin_ref, 64'd0);
    check("abort s_ref", bus0.s_end_ref, 64'd0);
    check("abort width", bus0.qrs_width, 64'd0);
    check("abort ref_err", 64'(bus0.ref_err), 64'd0);
    step(8);

    // Legacy instance: refs lag the temps by one frame.
    for (int k = 0; k < NCH; k++) begin
      set_lead(1, k, 16'd100, 16'd120, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_lead(k, 16'd92, 16'd135, 16'd0, 16'd0, 16'd0, 1'b1);
    end
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q1.push_back(stage);
    strobe(1);
    step(5);
    for (int k = 0; k < NCH; k++) begin
      exp_lead(k, 16'd92, 16'd135, 16'd736, 16'd1080, 16'd344, 1'b0);
    end
    t0 = cyc;
    stage.cyc = 32'(t0 + NCH + 1);
    q1.push_back(stage);
    strobe(1);
    step(5);

    step(3);
    check("dut0 pending results", 64'(q0.size()), 64'd0);
    check("dut1 pending results", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
